weight_dumper: RTL and testbench
================================

Name: weight_dumper

Overview:
- Readback engine for the weight memories. On a start pulse it reads conv weights, conv biases, dense weights and dense biases in the same order and byte layout the host uses to load them.
- It streams every byte to the UART transmitter over a valid/ready handshake, then sends a trailing 8-bit checksum.
- The host uses it to verify a weight download byte-for-byte. It sits between the weight memories' read ports and uart_tx.

Parameters:
- L1_W_BYTES, 144, L1 conv weight bytes (conv_w addr 0..143)
- L1_B_BYTES, 64, L1 conv bias bytes (16 words, conv_b addr 0..15)
- L2_W_BYTES, 4608, L2 conv weight bytes (conv_w addr 144..4751)
- L2_B_BYTES, 128, L2 conv bias bytes (32 words, conv_b addr 16..47)
- DN_W_BYTES, 8000, dense weight bytes (dense_w addr 0..7999)
- DN_B_BYTES, 40, dense bias bytes (10 words, dense_b addr 0..9)
- CHECKSUM_EN, 1, 1 = append mod-256 sum byte after payload

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; ignored unless idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last byte handshakes
- conv_w_rd_addr  out  13  conv weight read address
- conv_w_rd_data  in  8  conv weight data; 1-cycle registered read latency
- conv_b_rd_addr  out  6  conv bias read address
- conv_b_rd_data  in  32  conv bias word; 1-cycle latency
- dense_w_rd_addr  out  13  dense weight read address
- dense_w_rd_data  in  8  dense weight data; 1-cycle latency
- dense_b_rd_addr  out  4  dense bias read address
- dense_b_rd_data  in  32  dense bias word; 1-cycle latency
- tx_data  out  8  byte to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte when tx_valid&&tx_ready
- byte_count  out  16  payload bytes sent so far (progress)

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs are 0, including busy, done, tx_valid, tx_data, all rd_addr and byte_count. Clears global_addr, byte_idx, checksum and word holding register. A reset mid-dump abandons the stream with no trailer.
- Address map on global_addr (0..12983, total 12984):
  - L1 weights: conv_w addr = ga.
  - L1 biases: conv_b addr = (ga-144)>>2.
  - L2 weights: conv_w addr = 144+(ga-208).
  - L2 biases: conv_b addr = 16+((ga-4816)>>2).
  - Dense weights: dense_w addr = ga-4944.
  - Dense biases: dense_b addr = (ga-12944)>>2.
- Bias bytes are little-endian. byte_idx 0 sends bits 7:0, then 15:8, 23:16, 31:24.
- A bias word is read once when byte_idx==0, held in a 32-bit register, and reused for byte_idx 1..3.
- States:
  - IDLE: start=1 -> FETCH, busy=1, ga=0, checksum=0, byte_count=0.
  - FETCH: drive the read address for the current segment; -> CAPTURE next cycle. For bias bytes with byte_idx!=0, skip FETCH/CAPTURE and go directly to SEND.
  - CAPTURE: rd_data is valid this cycle. Latch the byte, or the word for bias, into tx_data; assert tx_valid; -> SEND.
  - SEND: hold tx_data/tx_valid stable until tx_ready.
    - On handshake: checksum += tx_data (mod 256), byte_count += 1, ga += 1. Bias segments advance byte_idx mod 4.
    - Deassert tx_valid next cycle unless the next byte is already loaded.
    - If ga was 12983: -> TRAILER if CHECKSUM_EN, else -> FINISH. Otherwise -> FETCH, or SEND with the next bias byte.
  - TRAILER: tx_data = checksum, tx_valid=1. On handshake -> FINISH. The trailer is not counted in byte_count.
  - FINISH: done=1 for one cycle, busy=0, -> IDLE. byte_count holds 12984 until the next start.
- Minimum byte interval is 3 cycles for weights and 1 cycle for bias bytes 1..3; otherwise throughput is bounded by tx_ready.
- tx_valid never drops before its handshake, and tx_data never changes while tx_valid=1 and tx_ready=0.
- start asserted while busy is ignored. start in the same cycle as FINISH is ignored, and is accepted from IDLE the following cycle.
- Only the read address of the segment in use changes; other addresses hold their last value.

Test Plan:
- Constant tx_ready=1, conv_w[i]=i[7:0], all other memories 0 -> 12984 bytes. Byte 0=0x00, byte 143=0x8F. Trailer = sum of bytes mod 256. done pulses once; byte_count=12984.
- conv_b[0]=0x11223344 -> stream bytes 144..147 = 0x44,0x33,0x22,0x11. conv_b_rd_addr=0 is issued once for the word.
- dense_b[9]=0xDEADBEEF -> final payload bytes 0xEF,0xBE,0xAD,0xDE. dense_b_rd_addr=9.
- tx_ready randomly stalled (held low up to 20 cycles) -> tx_data/tx_valid stable during stall. Stream is identical to the no-stall case.
- start pulsed again at byte 500 -> ignored; the stream is unchanged and exactly one done is produced.
- rst low at byte 5000, then start again -> outputs zero immediately. The new dump restarts at ga=0 with checksum reset. CHECKSUM_EN=0 variant ends without a trailer.

Source files
------------

// File: rtl/weight_dumper.sv
// weight_dumper: streams conv/dense weight and bias memories to the UART
// transmitter in host load order, little-endian bias bytes, optional
// trailing mod-256 checksum byte.
// Ports: clk, rst (async active-low), start, busy, done,
//   {conv_w,conv_b,dense_w,dense_b}_rd_addr/_rd_data (1-cycle read latency),
//   tx_data/tx_valid/tx_ready (valid/ready handshake), byte_count (progress).
module weight_dumper #(
   parameter int L1_W_BYTES  = 144,
   parameter int L1_B_BYTES  = 64,
   parameter int L2_W_BYTES  = 4608,
   parameter int L2_B_BYTES  = 128,
   parameter int DN_W_BYTES  = 8000,
   parameter int DN_B_BYTES  = 40,
   parameter bit CHECKSUM_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [12:0] conv_w_rd_addr,
   input  logic [7:0]  conv_w_rd_data,
   output logic [5:0]  conv_b_rd_addr,
   input  logic [31:0] conv_b_rd_data,
   output logic [12:0] dense_w_rd_addr,
   input  logic [7:0]  dense_w_rd_data,
   output logic [3:0]  dense_b_rd_addr,
   input  logic [31:0] dense_b_rd_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [15:0] byte_count
);

   localparam int L1B_BASE = L1_W_BYTES;
   localparam int L2W_BASE = L1B_BASE + L1_B_BYTES;
   localparam int L2B_BASE = L2W_BASE + L2_W_BYTES;
   localparam int DNW_BASE = L2B_BASE + L2_B_BYTES;
   localparam int DNB_BASE = DNW_BASE + DN_W_BYTES;
   localparam logic [13:0] GA_LAST = 14'(DNB_BASE + DN_B_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_CAPTURE, S_SEND, S_TRAILER, S_FINISH
   } state_e;

   typedef enum logic [2:0] {
      SEG_L1W, SEG_L1B, SEG_L2W, SEG_L2B, SEG_DNW, SEG_DNB
   } seg_e;

   function automatic seg_e seg_of(input logic [13:0] ga);
      seg_e s;
      if (ga < 14'(L1B_BASE))      s = SEG_L1W;
      else if (ga < 14'(L2W_BASE)) s = SEG_L1B;
      else if (ga < 14'(L2B_BASE)) s = SEG_L2W;
      else if (ga < 14'(DNW_BASE)) s = SEG_L2B;
      else if (ga < 14'(DNB_BASE)) s = SEG_DNW;
      else                         s = SEG_DNB;
      return s;
   endfunction

   state_e      r_state, w_state_n;
   logic [13:0] r_ga, w_tga, w_rel;
   logic [1:0]  r_bidx, w_bidx_n;
   logic [7:0]  r_sum;
   logic [31:0] r_word, w_cap_word;
   logic [7:0]  w_cap_byte;
   seg_e        w_seg, w_tseg;
   logic        w_hs, w_last, w_load, w_bias;

   assign busy   = (r_state != S_IDLE) && (r_state != S_FINISH);
   assign done   = (r_state == S_FINISH);
   assign w_seg  = seg_of(r_ga);
   assign w_hs   = tx_valid & tx_ready;
   assign w_last = (r_ga == GA_LAST);
   assign w_bias = (w_seg == SEG_L1B) || (w_seg == SEG_L2B) ||
                   (w_seg == SEG_DNB);
   assign w_bidx_n = w_bias ? r_bidx + 2'd1 : r_bidx;

   // Target of the next address load: 0 on start, ga+1 after a handshake.
   assign w_tga  = (r_state == S_IDLE) ? '0 : r_ga + 14'd1;
   assign w_tseg = seg_of(w_tga);
   assign w_load = ((r_state == S_IDLE) && start) ||
                   ((r_state == S_SEND) && w_hs && !w_last);

   always_comb begin
      w_rel = w_tga;
      case (w_tseg)
         SEG_L1B: w_rel = w_tga - 14'(L1B_BASE);
         SEG_L2W: w_rel = w_tga - 14'(L2W_BASE);
         SEG_L2B: w_rel = w_tga - 14'(L2B_BASE);
         SEG_DNW: w_rel = w_tga - 14'(DNW_BASE);
         SEG_DNB: w_rel = w_tga - 14'(DNB_BASE);
         default: w_rel = w_tga;
      endcase
   end

   always_comb begin
      w_cap_word = conv_b_rd_data;
      w_cap_byte = conv_w_rd_data;
      case (w_seg)
         SEG_L1B, SEG_L2B: w_cap_byte = conv_b_rd_data[7:0];
         SEG_DNW:          w_cap_byte = dense_w_rd_data;
         SEG_DNB: begin
            w_cap_word = dense_b_rd_data;
            w_cap_byte = dense_b_rd_data[7:0];
         end
         default: w_cap_byte = conv_w_rd_data;
      endcase
   end

   always_comb begin
      w_state_n = r_state;
      unique case (r_state)
         S_IDLE:    if (start) w_state_n = S_FETCH;
         S_FETCH:   w_state_n = S_CAPTURE;
         S_CAPTURE: w_state_n = S_SEND;
         S_SEND: begin
            if (w_hs) begin
               if (w_last)
                  w_state_n = CHECKSUM_EN ? S_TRAILER : S_FINISH;
               else if (w_bidx_n != 2'd0)
                  w_state_n = S_SEND;
               else
                  w_state_n = S_FETCH;
            end
         end
         S_TRAILER: if (w_hs) w_state_n = S_FINISH;
         S_FINISH:  w_state_n = S_IDLE;
         default:   w_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_n;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ga            <= '0;
         r_bidx          <= '0;
         r_sum           <= '0;
         r_word          <= '0;
         tx_data         <= '0;
         tx_valid        <= 1'b0;
         byte_count      <= '0;
         conv_w_rd_addr  <= '0;
         conv_b_rd_addr  <= '0;
         dense_w_rd_addr <= '0;
         dense_b_rd_addr <= '0;
      end else begin
         // Only the segment being read moves its address.
         if (w_load) begin
            r_ga <= w_tga;
            case (w_tseg)
               SEG_L1W: conv_w_rd_addr  <= 13'(w_rel);
               SEG_L1B: conv_b_rd_addr  <= 6'(w_rel >> 2);
               SEG_L2W: conv_w_rd_addr  <= 13'(L1_W_BYTES) + 13'(w_rel);
               SEG_L2B: conv_b_rd_addr  <= 6'(L1_B_BYTES / 4) +
                                           6'(w_rel >> 2);
               SEG_DNW: dense_w_rd_addr <= 13'(w_rel);
               SEG_DNB: dense_b_rd_addr <= 4'(w_rel >> 2);
               default: ;
            endcase
         end
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sum      <= '0;
                  r_bidx     <= '0;
                  byte_count <= '0;
               end
            end
            S_CAPTURE: begin
               tx_valid <= 1'b1;
               tx_data  <= w_cap_byte;
               r_word   <= w_cap_word;
            end
            S_SEND: begin
               if (w_hs) begin
                  r_sum      <= r_sum + tx_data;
                  byte_count <= byte_count + 16'd1;
                  r_bidx     <= w_bidx_n;
                  if (w_last) begin
                     tx_valid <= CHECKSUM_EN;
                     if (CHECKSUM_EN) tx_data <= r_sum + tx_data;
                  end else if (w_bidx_n != 2'd0) begin
                     // Remaining bias bytes come from the held word.
                     tx_data <= r_word[{w_bidx_n, 3'b000} +: 8];
                  end else begin
                     tx_valid <= 1'b0;
                  end
               end
            end
            S_TRAILER: if (w_hs) tx_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_dumper.sv
// tb_weight_dumper: scoreboard bench for weight_dumper; stalled stream with
// mid-dump reset and restart, plus a checksum-disabled instance.
module tb_weight_dumper;

   localparam int TOTAL = 12984;

   logic        clk, rst, rst0, start, start0;
   logic        busy, done, busy0, done0;
   logic [12:0] cw_a, dw_a, cw_a0, dw_a0;
   logic [5:0]  cb_a, cb_a0;
   logic [3:0]  db_a, db_a0;
   logic [7:0]  cw_q, dw_q, cw_q0, dw_q0;
   logic [31:0] cb_q, db_q, cb_q0, db_q0;
   logic [7:0]  tx_data, tx_data0;
   logic        tx_valid, tx_ready, tx_valid0, tx_ready0;
   logic [15:0] byte_count, byte_count0;

   logic [7:0]  cw_mem [0:8191];
   logic [7:0]  dw_mem [0:8191];
   logic [31:0] cb_mem [0:63];
   logic [31:0] db_mem [0:15];

   logic [7:0]  exp_q [$];
   logic [7:0]  rx [0:TOTAL];
   int vec = 0, bad = 0;
   int rx_idx = 0, idx0 = 0;
   int done_cnt = 0, done0_cnt = 0;
   int stall_left = 0;
   bit stall_en = 0;
   bit p_stall = 0;
   logic [7:0] p_data;

   weight_dumper dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .conv_w_rd_addr(cw_a), .conv_w_rd_data(cw_q),
      .conv_b_rd_addr(cb_a), .conv_b_rd_data(cb_q),
      .dense_w_rd_addr(dw_a), .dense_w_rd_data(dw_q),
      .dense_b_rd_addr(db_a), .dense_b_rd_data(db_q),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .byte_count(byte_count)
   );

   weight_dumper #(.CHECKSUM_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst0), .start(start0), .busy(busy0), .done(done0),
      .conv_w_rd_addr(cw_a0), .conv_w_rd_data(cw_q0),
      .conv_b_rd_addr(cb_a0), .conv_b_rd_data(cb_q0),
      .dense_w_rd_addr(dw_a0), .dense_w_rd_data(dw_q0),
      .dense_b_rd_addr(db_a0), .dense_b_rd_data(db_q0),
      .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
      .byte_count(byte_count0)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cw_q  <= cw_mem[cw_a];   cb_q  <= cb_mem[cb_a];
      dw_q  <= dw_mem[dw_a];   db_q  <= db_mem[db_a];
      cw_q0 <= cw_mem[cw_a0];  cb_q0 <= cb_mem[cb_a0];
      dw_q0 <= dw_mem[dw_a0];  db_q0 <= db_mem[db_a0];
   end

   function automatic logic [7:0] bias_byte(input logic [31:0] w,
                                            input int k);
      return 8'(w >> (8 * k));
   endfunction

   function automatic logic [7:0] exp_byte(input int ga);
      if (ga < 144)   return cw_mem[ga];
      if (ga < 208)   return bias_byte(cb_mem[(ga-144)/4], (ga-144)%4);
      if (ga < 4816)  return cw_mem[ga-64];
      if (ga < 4944)  return bias_byte(cb_mem[16+(ga-4816)/4],
                                       (ga-4816)%4);
      if (ga < 12944) return dw_mem[ga-4944];
      return bias_byte(db_mem[(ga-12944)/4], (ga-12944)%4);
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push_stream();
      for (int i = 0; i < TOTAL; i++) exp_q.push_back(exp_byte(i));
      exp_q.push_back(8'h1A);
   endtask

   // Random back-pressure on the main instance.
   initial begin
      tx_ready = 1;
      forever begin
         @(posedge clk); #1;
         if (stall_left > 0) begin
            tx_ready = 0;
            stall_left--;
         end else begin
            tx_ready = 1;
            if (stall_en && $urandom_range(0, 47) == 0)
               stall_left = $urandom_range(1, 20);
         end
      end
   end

   // Scoreboard monitor plus stall-stability check.
   always @(negedge clk) begin
      logic [7:0] e;
      if (!rst) begin
         p_stall = 0;
      end else begin
         if (p_stall) begin
            vec++;
            if (!tx_valid || tx_data !== p_data) begin
               bad++;
               $display("FAIL stall_hold: valid=%0b data=%0h want 1/%0h",
                        tx_valid, tx_data, p_data);
            end
         end
         if (tx_valid && tx_ready) begin
            vec++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL extra_byte: got %0h want none", tx_data);
            end else begin
               e = exp_q.pop_front();
               if (tx_data !== e) begin
                  bad++;
                  $display("FAIL byte[%0d]: got %0h want %0h",
                           rx_idx, tx_data, e);
               end
            end
            if (rx_idx <= TOTAL) rx[rx_idx] = tx_data;
            rx_idx++;
         end
         p_stall = tx_valid && !tx_ready;
         p_data  = tx_data;
      end
      if (done)  done_cnt++;
      if (done0) done0_cnt++;
   end

   // Checksum-disabled instance: payload only, never a trailer.
   always @(negedge clk) begin
      if (rst0 && tx_valid0 && tx_ready0) begin
         vec++;
         if (idx0 >= TOTAL) begin
            bad++;
            $display("FAIL no_trailer: got %0h want none", tx_data0);
         end else if (tx_data0 !== exp_byte(idx0)) begin
            bad++;
            $display("FAIL byte0[%0d]: got %0h want %0h",
                     idx0, tx_data0, exp_byte(idx0));
         end
         idx0++;
      end
   end

   initial begin
      int n;
      rst = 0; rst0 = 0; start = 0; start0 = 0; tx_ready0 = 1;
      for (int i = 0; i < 8192; i++) begin
         cw_mem[i] = (i < 4752) ? 8'(i) : 8'h00;
         dw_mem[i] = 8'h00;
      end
      for (int i = 0; i < 64; i++) cb_mem[i] = 32'h0;
      for (int i = 0; i < 16; i++) db_mem[i] = 32'h0;
      cb_mem[0] = 32'h11223344;
      db_mem[9] = 32'hDEADBEEF;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", tx_valid, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_count", byte_count, 0);
      chk("rst_cw_addr", cw_a, 0);
      rst = 1; rst0 = 1;

      // Dump 1: stalled, abandoned by reset at byte 5000.
      stall_en = 1;
      push_stream();
      @(posedge clk); #1;
      start = 1; start0 = 1;
      @(posedge clk); #1;
      start = 0; start0 = 0;
      chk("busy_after_start", busy, 1);
      n = 0;
      while (rx_idx < 5000 && n < 40000) begin
         @(posedge clk); n++;
      end
      if (rx_idx < 5000) begin
         bad++;
         $display("FAIL timeout_5000: got %0d want 5000", rx_idx);
      end
      #1;
      rst = 0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", tx_valid, 0);
      chk("mid_rst_data", tx_data, 0);
      chk("mid_rst_count", byte_count, 0);
      chk("mid_rst_cw_addr", cw_a, 0);
      chk("mid_rst_cb_addr", cb_a, 0);
      chk("no_done_before_rst", done_cnt, 0);
      exp_q.delete();
      rx_idx = 0;
      @(posedge clk); #1;
      rst = 1;

      // Dump 2: full run, stray start at byte 500.
      push_stream();
      @(posedge clk); #1;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      n = 0;
      while (rx_idx < 500 && n < 5000) begin
         @(posedge clk); n++;
      end
      #1;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      n = 0;
      while (done_cnt == 0 && n < 80000) begin
         @(posedge clk); n++;
      end
      if (done_cnt == 0) begin
         bad++;
         $display("FAIL timeout_done: got 0 want 1");
      end
      repeat (5) @(posedge clk);
      #1;
      chk("done_once", done_cnt, 1);
      chk("final_count", byte_count, TOTAL);
      chk("final_busy", busy, 0);
      chk("final_valid", tx_valid, 0);
      chk("queue_drained", exp_q.size(), 0);
      chk("rx_count", rx_idx, TOTAL + 1);
      chk("byte0", rx[0], 8'h00);
      chk("byte143", rx[143], 8'h8F);
      chk("byte144", rx[144], 8'h44);
      chk("byte145", rx[145], 8'h33);
      chk("byte146", rx[146], 8'h22);
      chk("byte147", rx[147], 8'h11);
      chk("byte12980", rx[12980], 8'hEF);
      chk("byte12981", rx[12981], 8'hBE);
      chk("byte12982", rx[12982], 8'hAD);
      chk("byte12983", rx[12983], 8'hDE);
      chk("trailer", rx[TOTAL], 8'h1A);
      chk("cw_addr_hold", cw_a, 4751);
      chk("cb_addr_hold", cb_a, 47);
      chk("dw_addr_hold", dw_a, 7999);
      chk("db_addr_hold", db_a, 9);

      n = 0;
      while (done0_cnt == 0 && n < 1000) begin
         @(posedge clk); n++;
      end
      repeat (5) @(posedge clk);
      #1;
      chk("nock_done_once", done0_cnt, 1);
      chk("nock_bytes", idx0, TOTAL);
      chk("nock_count", byte_count0, TOTAL);
      chk("nock_valid", tx_valid0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
